// File: rtl/reg_file_direct_arb.sv
// Register file with per-register access modes, a direct parallel hardware view,
// and a single-outstanding valid/ready bus port with a registered response.
module reg_file_direct_arb #(
  parameter int unsigned REGISTER_WIDTH = 32,
  parameter int unsigned NUM_REGISTERS  = 16,
  parameter logic [NUM_REGISTERS-1:0][REGISTER_WIDTH-1:0] RESET_VALUES = '0,
  parameter logic [NUM_REGISTERS-1:0][1:0] REG_MODES = '0
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [NUM_REGISTERS-1:0][REGISTER_WIDTH-1:0]   hw_write_data,
  input  logic [NUM_REGISTERS-1:0]                       hw_write_req,
  output logic [NUM_REGISTERS-1:0][REGISTER_WIDTH-1:0]   hw_read_data,
  input  logic                                           bus_req_valid,
  output logic                                           bus_req_ready,
  input  logic                                           bus_req_write,
  input  logic [$clog2(NUM_REGISTERS)-1:0]               bus_req_addr,
  input  logic [REGISTER_WIDTH-1:0]                      bus_req_wdata,
  input  logic [REGISTER_WIDTH/8-1:0]                    bus_req_strb,
  output logic                                           bus_rsp_valid,
  input  logic                                           bus_rsp_ready,
  output logic [REGISTER_WIDTH-1:0]                      bus_rsp_rdata,
  output logic                                           bus_rsp_err,
  output logic [NUM_REGISTERS-1:0]                       bus_wr_pulse
);

  localparam int unsigned AW = $clog2(NUM_REGISTERS);
  localparam int unsigned NB = REGISTER_WIDTH / 8;

  typedef enum logic [1:0] {
    MODE_RW  = 2'd0,
    MODE_RO  = 2'd1,
    MODE_W1C = 2'd2,
    MODE_W1S = 2'd3
  } mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  state_e                                         state_q, state_d;
  logic [NUM_REGISTERS-1:0][REGISTER_WIDTH-1:0]   regs_q, regs_d;
  logic [REGISTER_WIDTH-1:0]                      rsp_rdata_q, rsp_rdata_d;
  logic                                           rsp_err_q, rsp_err_d;
  logic [NUM_REGISTERS-1:0]                       wr_pulse_q, wr_pulse_d;

  logic                                           accept;
  logic                                           addr_ok;
  logic [REGISTER_WIDTH-1:0]                      addr_val;
  mode_e                                          addr_mode;
  logic [REGISTER_WIDTH-1:0]                      wmask;
  logic [REGISTER_WIDTH-1:0]                      bus_bits;
  logic [NUM_REGISTERS-1:0]                       bus_hit;

  always_comb begin
    state_d     = state_q;
    regs_d      = regs_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    wr_pulse_d  = '0;
    accept      = (state_q == IDLE) && bus_req_valid;
    addr_ok     = 1'b0;
    addr_val    = '0;
    addr_mode   = MODE_RW;
    wmask       = '0;
    bus_hit     = '0;

    for (int unsigned b = 0; b < NB; b++) begin
      wmask[b*8 +: 8] = {8{bus_req_strb[b]}};
    end
    bus_bits = bus_req_wdata & wmask;

    // Address decode by comparison so non-power-of-two counts never index past the array.
    for (int unsigned i = 0; i < NUM_REGISTERS; i++) begin
      if (bus_req_addr == AW'(i)) begin
        addr_ok   = 1'b1;
        addr_val  = regs_q[i];
        addr_mode = mode_e'(REG_MODES[i]);
      end
    end

    for (int unsigned i = 0; i < NUM_REGISTERS; i++) begin
      bus_hit[i] = accept && bus_req_write && (bus_req_addr == AW'(i)) &&
                   (mode_e'(REG_MODES[i]) != MODE_RO);
      // Ordering within each mode encodes the priority: the later update wins.
      case (mode_e'(REG_MODES[i]))
        MODE_RW: begin
          if (bus_hit[i]) regs_d[i] = (regs_q[i] & ~wmask) | bus_bits;
          if (hw_write_req[i]) regs_d[i] = hw_write_data[i];
        end
        MODE_RO: begin
          if (hw_write_req[i]) regs_d[i] = hw_write_data[i];
        end
        MODE_W1C: begin
          if (bus_hit[i]) regs_d[i] = regs_d[i] & ~bus_bits;
          if (hw_write_req[i]) regs_d[i] = regs_d[i] | hw_write_data[i];
        end
        MODE_W1S: begin
          if (hw_write_req[i]) regs_d[i] = regs_d[i] & ~hw_write_data[i];
          if (bus_hit[i]) regs_d[i] = regs_d[i] | bus_bits;
        end
        default: ;
      endcase
    end
    wr_pulse_d = bus_hit;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d     = RESP;
          rsp_rdata_d = (!bus_req_write && addr_ok) ? addr_val : '0;
          rsp_err_d   = !addr_ok || (bus_req_write && addr_mode == MODE_RO);
        end
      end
      RESP: begin
        if (bus_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      regs_q      <= RESET_VALUES;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      wr_pulse_q  <= '0;
    end else begin
      state_q     <= state_d;
      regs_q      <= regs_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      wr_pulse_q  <= wr_pulse_d;
    end
  end

  assign hw_read_data  = regs_q;
  assign bus_req_ready = (state_q == IDLE);
  assign bus_rsp_valid = (state_q == RESP);
  assign bus_rsp_rdata = rsp_rdata_q;
  assign bus_rsp_err   = rsp_err_q;
  assign bus_wr_pulse  = wr_pulse_q;

endmodule
